xif_result_buffer: RTL
======================

Name: xif_result_buffer

Overview:
- In-order result buffer between the FPU execution pipeline and the CORE-V-XIF result channel of the rvfpm coprocessor.
- Captures completed FPU results and tracks commit/kill per instruction ID from the XIF commit channel.
- Presents only committed, non-killed results on the XIF result handshake; silently discards killed results.

Parameters:
XLEN, 32, integer register width
X_ID_WIDTH, 4, XIF instruction ID width; scoreboard has 2**X_ID_WIDTH entries
X_RFW_WIDTH, 32, XIF result data width
DEPTH, 4, buffer entries; power of two, >=2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fpu_valid  in  1  FPU result available
fpu_ready  out  1  buffer accepts FPU result
fpu_id  in  X_ID_WIDTH  instruction ID
fpu_data  in  X_RFW_WIDTH  integer writeback data
fpu_rd  in  5  destination register
fpu_we  in  X_RFW_WIDTH/XLEN  integer write enable
fpu_fs_dirty  in  1  instruction modified FP state
fpu_exc  in  1  synchronous exception
fpu_exccode  in  6  exception code
commit_valid  in  1  XIF commit strobe
commit_id  in  X_ID_WIDTH  committed/killed ID
commit_kill  in  1  kill instruction
result_valid  out  1  XIF result valid
result_ready  in  1  XIF result ready
result_id  out  X_ID_WIDTH
result_data  out  X_RFW_WIDTH
result_rd  out  5
result_we  out  X_RFW_WIDTH/XLEN
result_ecsdata  out  6  {xs,fs,vs}
result_ecswe  out  3
result_exc  out  1
result_exccode  out  6
result_err  out  1  tied 0
result_dbg  out  1  tied 0
drop_pulse  out  1  one-cycle pulse when a killed entry is discarded
count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- The clock is clk; reset is rst, synchronous and active-high. One clock domain.
- Reset: pointers, count, storage, and scoreboard cleared. Outputs after reset: result_valid=0, all result_* fields=0, drop_pulse=0, count=0, fpu_ready=1.
- Reset asserted mid-operation discards all entries and commit state on that edge.
- Storage: circular FIFO of DEPTH entries. Each entry holds {id, data, rd, we, fs_dirty, exc, exccode}. Read and write pointers wrap modulo DEPTH.
- fpu_ready = (count != DEPTH), combinational.
- Push occurs when fpu_valid && fpu_ready. When full, fpu_ready=0 even if a pop occurs in the same cycle; there is no full bypass.
- Scoreboard: per-ID bits cmt[] and kil[]. On commit_valid, set cmt[commit_id]=1 and kil[commit_id]=commit_kill.
- Commits may arrive before or after the corresponding FPU result.
- Head state, evaluated when count>0, from registers only:
  - WAIT: cmt[head.id]=0. result_valid=0; head is held. Head-of-line blocking is intended.
  - PRESENT: cmt=1, kil=0. result_valid=1; fields driven from head combinationally. Pop on result_valid && result_ready.
  - DROP: cmt=1, kil=1. result_valid=0; head popped unconditionally that cycle; drop_pulse=1.
- A commit for the head ID takes effect one cycle later: the earliest result_valid is the cycle after commit_valid.
- On pop (present or drop), clear cmt[head.id] and kil[head.id]. If commit_valid for the same ID occurs in the same cycle, the set wins (ID reuse).
- Stability: while result_valid && !result_ready, all result_* fields and result_valid are held constant.
- Push and pop in the same cycle: count unchanged.
- result_ecswe = {1'b0, fs_dirty, 1'b0}. result_ecsdata = fs_dirty ? 6'b00_11_00 : 6'b0.
- When result_valid=0, result_* fields show head contents; the bench must not check them.
- Latency: an FPU result whose commit arrived earlier appears on result_valid the cycle after push.
- Throughput: one result per cycle when result_ready is held high.

Test Plan:
- Commit first: commit id=3 kill=0; next cycle push id=3 data=0x3F800000 rd=5 we=1 fs_dirty=1 -> result_valid=1 the following cycle, result_id=3, data=0x3F800000, rd=5, ecswe=3'b010, ecsdata=6'b001100; result_ready=1 -> count=0, cmt[3]=0.
- Kill: push id=2, then commit id=2 kill=1 -> result_valid never asserts, drop_pulse=1 for exactly one cycle, count 1->0.
- Backpressure: committed head id=7 data=0xDEADBEEF, result_ready=0 for 5 cycles -> result_valid and all fields held constant; then ready=1 -> single pop.
- Full: DEPTH=4, push ids 0..3 with no commits -> count=4, fpu_ready=0, 5th fpu_valid not accepted; commit id=0 -> head presented and popped, then fpu_ready=1.
- Ordering: push ids 1,2; commit 2 then commit 1 -> nothing presented until commit 1; then id 1 and id 2 presented on consecutive cycles with ready=1.
- Reset mid-operation: 3 entries buffered, one presenting; rst for 1 cycle -> next cycle result_valid=0, count=0, fpu_ready=1; a late commit for an old ID presents nothing.

Source files
------------

// File: rtl/xif_result_buffer.sv
// xif_result_buffer
// -----------------
// In-order result buffer that sits between the FPU execution pipeline and the
// CORE-V-XIF result channel. Completed FPU results are queued in a small
// circular FIFO. A per-ID scoreboard records commit/kill information from the
// XIF commit channel. Only the head entry is examined:
//   - not yet committed      -> held (head-of-line blocking)
//   - committed, not killed  -> presented on the result handshake
//   - committed and killed   -> discarded silently, drop_pulse asserted
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   fpu_*                    result capture interface (valid/ready)
//   commit_*                 XIF commit strobe, ID and kill flag
//   result_*                 XIF result channel (valid/ready + payload)
//   drop_pulse               high during the cycle a killed head is discarded
//   count                    current FIFO occupancy
module xif_result_buffer #(
    parameter int XLEN        = 32,
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFW_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fpu_valid,
    output logic                          fpu_ready,
    input  logic [X_ID_WIDTH-1:0]         fpu_id,
    input  logic [X_RFW_WIDTH-1:0]        fpu_data,
    input  logic [4:0]                    fpu_rd,
    input  logic [X_RFW_WIDTH/XLEN-1:0]   fpu_we,
    input  logic                          fpu_fs_dirty,
    input  logic                          fpu_exc,
    input  logic [5:0]                    fpu_exccode,
    input  logic                          commit_valid,
    input  logic [X_ID_WIDTH-1:0]         commit_id,
    input  logic                          commit_kill,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic [X_ID_WIDTH-1:0]         result_id,
    output logic [X_RFW_WIDTH-1:0]        result_data,
    output logic [4:0]                    result_rd,
    output logic [X_RFW_WIDTH/XLEN-1:0]   result_we,
    output logic [5:0]                    result_ecsdata,
    output logic [2:0]                    result_ecswe,
    output logic                          result_exc,
    output logic [5:0]                    result_exccode,
    output logic                          result_err,
    output logic                          result_dbg,
    output logic                          drop_pulse,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int NID  = 2 ** X_ID_WIDTH;
    localparam int WE_W = X_RFW_WIDTH / XLEN;

    // FIFO storage, one register set per entry
    logic [X_ID_WIDTH-1:0]  id_q      [DEPTH];
    logic [X_RFW_WIDTH-1:0] data_q    [DEPTH];
    logic [4:0]             rd_q      [DEPTH];
    logic [WE_W-1:0]        we_q      [DEPTH];
    logic                   fsd_q     [DEPTH];
    logic                   exc_q     [DEPTH];
    logic [5:0]             exccode_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [NID-1:0] cmt_q, cmt_d;
    logic [NID-1:0] kil_q, kil_d;

    logic                  push;
    logic                  pop;
    logic                  not_empty;
    logic [X_ID_WIDTH-1:0] head_id;
    logic                  head_cmt;
    logic                  head_kil;

    assign fpu_ready = (count_q != CW'(DEPTH));
    assign push      = fpu_valid && fpu_ready;
    assign not_empty = (count_q != '0);
    assign head_id   = id_q[rd_ptr_q];
    assign head_cmt  = cmt_q[head_id];
    assign head_kil  = kil_q[head_id];

    // Head decision uses registered scoreboard only, so a commit for the head
    // becomes visible one cycle after the strobe.
    assign result_valid = not_empty && head_cmt && !head_kil;
    assign drop_pulse   = not_empty && head_cmt && head_kil;
    assign pop          = (result_valid && result_ready) || drop_pulse;

    // Payload always reflects the head entry; storage is cleared on reset so
    // the fields read zero until the first push.
    assign result_id      = head_id;
    assign result_data    = data_q[rd_ptr_q];
    assign result_rd      = rd_q[rd_ptr_q];
    assign result_we      = we_q[rd_ptr_q];
    assign result_exc     = exc_q[rd_ptr_q];
    assign result_exccode = exccode_q[rd_ptr_q];
    assign result_ecswe   = {1'b0, fsd_q[rd_ptr_q], 1'b0};
    assign result_ecsdata = fsd_q[rd_ptr_q] ? 6'b00_11_00 : 6'b00_00_00;
    assign result_err     = 1'b0;
    assign result_dbg     = 1'b0;
    assign count          = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pop clears the head's bits first; a commit for the same ID in the same
    // cycle is applied afterwards so a reused ID keeps its new commit.
    always_comb begin
        cmt_d = cmt_q;
        kil_d = kil_q;
        if (pop) begin
            cmt_d[head_id] = 1'b0;
            kil_d[head_id] = 1'b0;
        end
        if (commit_valid) begin
            cmt_d[commit_id] = 1'b1;
            kil_d[commit_id] = commit_kill;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cmt_q    <= '0;
            kil_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cmt_q    <= cmt_d;
            kil_q    <= kil_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    id_q[gi]      <= '0;
                    data_q[gi]    <= '0;
                    rd_q[gi]      <= '0;
                    we_q[gi]      <= '0;
                    fsd_q[gi]     <= 1'b0;
                    exc_q[gi]     <= 1'b0;
                    exccode_q[gi] <= '0;
                end else if (push && (wr_ptr_q == PW'(gi))) begin
                    id_q[gi]      <= fpu_id;
                    data_q[gi]    <= fpu_data;
                    rd_q[gi]      <= fpu_rd;
                    we_q[gi]      <= fpu_we;
                    fsd_q[gi]     <= fpu_fs_dirty;
                    exc_q[gi]     <= fpu_exc;
                    exccode_q[gi] <= fpu_exccode;
                end
            end
        end
    endgenerate

endmodule
